gpr_port_ctrl: RTL and testbench

Access controller for the general-purpose register file. It drives both ports of an instantiated dual_port_SRAM on behalf of the CPU pipeline. The pipeline sends one operand-read request (two addresses) and up to two writebacks per cycle. The block zero-initialises the array after reset, resolves writes from both ports to the same address, forwards writeback data onto reads of the same address in the same cycle, and handshakes read responses.

---
 rtl/gpr_pkg.sv | 18 +
 rtl/gpr_port_ctrl_if.sv | 41 ++++
 rtl/dual_port_SRAM.sv | 37 +++
 rtl/gpr_port_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_gpr_port_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpr_pkg.sv
// gpr_pkg: shared types for the general-purpose register file access controller.
//   gpr_state_e : controller FSM states (clear sequence, normal operation)
//   fwd_sel_e   : per-operand source select for a read response
package gpr_pkg;

  typedef enum logic [0:0] {
    StClear,
    StRun
  } gpr_state_e;

  typedef enum logic [1:0] {
    FwdSram,  // pre-existing array contents
    FwdWbA,   // same-cycle writeback A
    FwdWbB,   // same-cycle writeback B (younger, higher priority)
    FwdZero   // hard-wired zero register or out-of-range address
  } fwd_sel_e;

endpackage

// File: rtl/gpr_port_ctrl_if.sv
// gpr_port_ctrl_if: pipeline <-> register file controller bundle.
//   Read request : rd_req_valid/rd_req_ready, rd_addr_a/b
//   Read response: rd_rsp_valid (one-cycle pulse), rd_data_a/b
//   Writebacks   : wb_valid_a/b, wb_addr_a/b, wb_data_a/b, wb_ready
//   Status       : init_done
// master = pipeline side, slave = controller side.
interface gpr_port_ctrl_if #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned DEPTH     = 8
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic                 init_done;
  logic                 rd_req_valid;
  logic                 rd_req_ready;
  logic [ADDR_W-1:0]    rd_addr_a;
  logic [ADDR_W-1:0]    rd_addr_b;
  logic                 rd_rsp_valid;
  logic [BUS_WIDTH-1:0] rd_data_a;
  logic [BUS_WIDTH-1:0] rd_data_b;
  logic                 wb_valid_a;
  logic [ADDR_W-1:0]    wb_addr_a;
  logic [BUS_WIDTH-1:0] wb_data_a;
  logic                 wb_valid_b;
  logic [ADDR_W-1:0]    wb_addr_b;
  logic [BUS_WIDTH-1:0] wb_data_b;
  logic                 wb_ready;

  modport master (
    input  init_done, rd_req_ready, rd_rsp_valid, rd_data_a, rd_data_b, wb_ready,
    output rd_req_valid, rd_addr_a, rd_addr_b,
    output wb_valid_a, wb_addr_a, wb_data_a, wb_valid_b, wb_addr_b, wb_data_b
  );

  modport slave (
    output init_done, rd_req_ready, rd_rsp_valid, rd_data_a, rd_data_b, wb_ready,
    input  rd_req_valid, rd_addr_a, rd_addr_b,
    input  wb_valid_a, wb_addr_a, wb_data_a, wb_valid_b, wb_addr_b, wb_data_b
  );

endinterface

// File: rtl/dual_port_SRAM.sv
// dual_port_SRAM: register array with two ports, each able to read one address and write
// another in the same cycle. Reads are synchronous and return pre-write data on a
// same-address collision. No reset on the array or read registers.
//   clk                 : clock
//   we_x/waddr_x/wdata_x: port x write
//   re_x/raddr_x        : port x read enable/address
//   rdata_x             : port x read data, valid the cycle after re_x
module dual_port_SRAM #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       we_a,
  input  logic [$clog2(DEPTH)-1:0]   waddr_a,
  input  logic [BUS_WIDTH-1:0]       wdata_a,
  input  logic                       re_a,
  input  logic [$clog2(DEPTH)-1:0]   raddr_a,
  output logic [BUS_WIDTH-1:0]       rdata_a,
  input  logic                       we_b,
  input  logic [$clog2(DEPTH)-1:0]   waddr_b,
  input  logic [BUS_WIDTH-1:0]       wdata_b,
  input  logic                       re_b,
  input  logic [$clog2(DEPTH)-1:0]   raddr_b,
  output logic [BUS_WIDTH-1:0]       rdata_b
);

  logic [BUS_WIDTH-1:0] mem [DEPTH];

  // Single process so both ports can write the array; port b is applied last.
  always_ff @(posedge clk) begin
    if (re_a) rdata_a <= mem[raddr_a];
    if (re_b) rdata_b <= mem[raddr_b];
    if (we_a) mem[waddr_a] <= wdata_a;
    if (we_b) mem[waddr_b] <= wdata_b;
  end

endmodule

// File: rtl/gpr_port_ctrl.sv
// gpr_port_ctrl: register file access controller.
// Clears the array two entries per cycle after reset, then serves one two-operand read
// and up to two writebacks per cycle. Same-cycle writebacks are forwarded onto reads
// (B over A), same-address write conflicts keep only B, register 0 can be hard-wired to
// zero, and out-of-range addresses never reach the array.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gpr_port_ctrl_if slave (requests, responses, writebacks, init_done)
module gpr_port_ctrl
  import gpr_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ZERO_REG  = 1
) (
  input logic            clk,
  input logic            rst_n,
  gpr_port_ctrl_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [BUS_WIDTH-1:0] data_t;

  function automatic logic in_range(addr_t a);
    return {1'b0, a} < DepthW;
  endfunction

  function automatic logic is_zero_reg(addr_t a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic fwd_sel_e pick_src(addr_t ra, logic wa_en, addr_t wa,
                                        logic wb_en, addr_t wb);
    if (!in_range(ra) || is_zero_reg(ra)) return FwdZero;
    if (wb_en && (wb == ra)) return FwdWbB;
    if (wa_en && (wa == ra)) return FwdWbA;
    return FwdSram;
  endfunction

  gpr_state_e      state_q, state_d;
  logic [ADDR_W:0] clr_ptr_q, clr_ptr_d, clr_ptr_p1, clr_ptr_p2;
  logic            run, rd_accept, wb_en_a, wb_en_b;

  logic  sram_we_a, sram_we_b, sram_re_a, sram_re_b;
  addr_t sram_waddr_a, sram_waddr_b, sram_raddr_a, sram_raddr_b;
  data_t sram_wdata_a, sram_wdata_b, sram_rdata_a, sram_rdata_b;

  fwd_sel_e sel_a_d, sel_b_d, sel_a_q, sel_b_q;
  logic     rsp_valid_q;
  data_t    wb_data_a_q, wb_data_b_q, hold_a_q, hold_b_q, rsp_a, rsp_b;

  assign run        = (state_q == StRun);
  assign rd_accept  = bus.rd_req_valid & run;
  assign clr_ptr_p1 = clr_ptr_q + 1'b1;
  assign clr_ptr_p2 = clr_ptr_q + 2'd2;

  // Dropped writebacks (zero register, out of range) are invisible to forwarding too.
  assign wb_en_a = run & bus.wb_valid_a & in_range(bus.wb_addr_a) & ~is_zero_reg(bus.wb_addr_a);
  assign wb_en_b = run & bus.wb_valid_b & in_range(bus.wb_addr_b) & ~is_zero_reg(bus.wb_addr_b);

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    sram_we_a    = 1'b0;
    sram_waddr_a = '0;
    sram_wdata_a = '0;
    sram_we_b    = 1'b0;
    sram_waddr_b = '0;
    sram_wdata_b = '0;
    sram_re_a    = 1'b0;
    sram_raddr_a = '0;
    sram_re_b    = 1'b0;
    sram_raddr_b = '0;
    sel_a_d      = pick_src(bus.rd_addr_a, wb_en_a, bus.wb_addr_a, wb_en_b, bus.wb_addr_b);
    sel_b_d      = pick_src(bus.rd_addr_b, wb_en_a, bus.wb_addr_a, wb_en_b, bus.wb_addr_b);

    unique case (state_q)
      StClear: begin
        sram_we_a    = 1'b1;
        sram_waddr_a = clr_ptr_q[ADDR_W-1:0];
        // Odd DEPTH: the last pair has no second entry.
        sram_we_b    = clr_ptr_p1 < DepthW;
        sram_waddr_b = sram_we_b ? clr_ptr_p1[ADDR_W-1:0] : '0;
        clr_ptr_d    = clr_ptr_p2;
        if (clr_ptr_p2 >= DepthW) state_d = StRun;
      end
      StRun: begin
        // Younger writeback wins a same-address conflict.
        sram_we_a    = wb_en_a & ~(wb_en_b & (bus.wb_addr_a == bus.wb_addr_b));
        sram_waddr_a = wb_en_a ? bus.wb_addr_a : '0;
        sram_wdata_a = bus.wb_data_a;
        sram_we_b    = wb_en_b;
        sram_waddr_b = wb_en_b ? bus.wb_addr_b : '0;
        sram_wdata_b = bus.wb_data_b;
        sram_re_a    = rd_accept & in_range(bus.rd_addr_a);
        sram_raddr_a = sram_re_a ? bus.rd_addr_a : '0;
        sram_re_b    = rd_accept & in_range(bus.rd_addr_b);
        sram_raddr_b = sram_re_b ? bus.rd_addr_b : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      clr_ptr_q   <= '0;
      rsp_valid_q <= 1'b0;
      sel_a_q     <= FwdZero;
      sel_b_q     <= FwdZero;
      wb_data_a_q <= '0;
      wb_data_b_q <= '0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      rsp_valid_q <= rd_accept;
      if (rd_accept) begin
        sel_a_q     <= sel_a_d;
        sel_b_q     <= sel_b_d;
        wb_data_a_q <= bus.wb_data_a;
        wb_data_b_q <= bus.wb_data_b;
      end
      if (rsp_valid_q) begin
        hold_a_q <= rsp_a;
        hold_b_q <= rsp_b;
      end
    end
  end

  // Forwarding mux sits after the array read register; inputs are all flops.
  always_comb begin
    rsp_a = '0;
    rsp_b = '0;
    unique case (sel_a_q)
      FwdSram: rsp_a = sram_rdata_a;
      FwdWbA:  rsp_a = wb_data_a_q;
      FwdWbB:  rsp_a = wb_data_b_q;
      FwdZero: rsp_a = '0;
      default: rsp_a = '0;
    endcase
    unique case (sel_b_q)
      FwdSram: rsp_b = sram_rdata_b;
      FwdWbA:  rsp_b = wb_data_a_q;
      FwdWbB:  rsp_b = wb_data_b_q;
      FwdZero: rsp_b = '0;
      default: rsp_b = '0;
    endcase
  end

  assign bus.init_done    = run;
  assign bus.rd_req_ready = run;
  assign bus.wb_ready     = run;
  assign bus.rd_rsp_valid = rsp_valid_q;
  assign bus.rd_data_a    = rsp_valid_q ? rsp_a : hold_a_q;
  assign bus.rd_data_b    = rsp_valid_q ? rsp_b : hold_b_q;

  dual_port_SRAM #(
    .BUS_WIDTH (BUS_WIDTH),
    .DEPTH     (DEPTH)
  ) u_sram (
    .clk     (clk),
    .we_a    (sram_we_a),
    .waddr_a (sram_waddr_a),
    .wdata_a (sram_wdata_a),
    .re_a    (sram_re_a),
    .raddr_a (sram_raddr_a),
    .rdata_a (sram_rdata_a),
    .we_b    (sram_we_b),
    .waddr_b (sram_waddr_b),
    .wdata_b (sram_wdata_b),
    .re_b    (sram_re_b),
    .raddr_b (sram_raddr_b),
    .rdata_b (sram_rdata_b)
  );

endmodule

// File: tb/tb_gpr_port_ctrl.sv
// tb_gpr_port_ctrl: scoreboard bench for gpr_port_ctrl (BUS_WIDTH=8, DEPTH=8, ZERO_REG=1).
// Each accepted read pushes its expected operands and due cycle; the negedge monitor
// pops and compares, and checks that rd_data holds between responses.
module tb_gpr_port_ctrl;

  localparam int Depth = 8;

  typedef struct {
    int         due;
    logic [7:0] a;
    logic [7:0] b;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  sb_t        sb[$];
  logic [7:0] model [Depth];
  logic [7:0] last_a = 8'h00;
  logic [7:0] last_b = 8'h00;
  logic       run_exp = 1'b0;

  gpr_port_ctrl_if #(.BUS_WIDTH(8), .DEPTH(Depth)) bus ();

  gpr_port_ctrl #(
    .BUS_WIDTH (8),
    .DEPTH     (Depth),
    .ZERO_REG  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic wr_ok(input logic v, input int addr);
    return v && (addr < Depth) && (addr != 0);
  endfunction

  function automatic logic [7:0] exp_read(input int addr, input logic wva, input int waa,
                                          input logic [7:0] wda, input logic wvb,
                                          input int wab, input logic [7:0] wdb);
    if (addr >= Depth || addr == 0) return 8'h00;
    if (wr_ok(wvb, wab) && wab == addr) return wdb;
    if (wr_ok(wva, waa) && waa == addr) return wda;
    return model[addr];
  endfunction

  task automatic set_idle();
    bus.rd_req_valid = 1'b0;
    bus.rd_addr_a    = 3'd0;
    bus.rd_addr_b    = 3'd0;
    bus.wb_valid_a   = 1'b0;
    bus.wb_addr_a    = 3'd0;
    bus.wb_data_a    = 8'h00;
    bus.wb_valid_b   = 1'b0;
    bus.wb_addr_b    = 3'd0;
    bus.wb_data_b    = 8'h00;
  endtask

  // Drive one cycle of stimulus and record what the array and response should be.
  task automatic cycle(input logic rv, input int ra, input int rb,
                       input logic wva, input int waa, input logic [7:0] wda,
                       input logic wvb, input int wab, input logic [7:0] wdb);
    sb_t e;
    @(posedge clk);
    #1;
    bus.rd_req_valid = rv;
    bus.rd_addr_a    = 3'(ra);
    bus.rd_addr_b    = 3'(rb);
    bus.wb_valid_a   = wva;
    bus.wb_addr_a    = 3'(waa);
    bus.wb_data_a    = wda;
    bus.wb_valid_b   = wvb;
    bus.wb_addr_b    = 3'(wab);
    bus.wb_data_b    = wdb;
    if (run_exp) begin
      if (rv) begin
        e.due = cyc + 1;
        e.a   = exp_read(ra, wva, waa, wda, wvb, wab, wdb);
        e.b   = exp_read(rb, wva, waa, wda, wvb, wab, wdb);
        sb.push_back(e);
      end
      if (wr_ok(wva, waa)) model[waa] = wda;
      if (wr_ok(wvb, wab)) model[wab] = wdb;
    end
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 0, 0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00);
  endtask

  // Call right after reset release on a negedge: clear takes Depth/2 edges.
  task automatic wait_init();
    for (int i = 1; i <= Depth / 2; i++) begin
      @(posedge clk);
      #1;
      chk("init_done", 32'(bus.init_done), 32'(i == Depth / 2));
      chk("rd_req_ready", 32'(bus.rd_req_ready), 32'(i == Depth / 2));
      chk("wb_ready", 32'(bus.wb_ready), 32'(i == Depth / 2));
    end
    run_exp = 1'b1;
  endtask

  task automatic flush_model();
    sb.delete();
    last_a  = 8'h00;
    last_b  = 8'h00;
    run_exp = 1'b0;
    for (int i = 0; i < Depth; i++) model[i] = 8'h00;
  endtask

  always @(negedge clk) begin
    sb_t  e;
    logic exp_v;
    exp_v = (sb.size() > 0) && (sb[0].due == cyc);
    chk("rsp_valid", 32'(bus.rd_rsp_valid), 32'(exp_v));
    if (exp_v) begin
      e      = sb.pop_front();
      last_a = e.a;
      last_b = e.b;
    end
    chk("rd_data_a", 32'(bus.rd_data_a), 32'(last_a));
    chk("rd_data_b", 32'(bus.rd_data_b), 32'(last_b));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rv, wva, wvb;
    int         ra, rb, waa, wab;
    logic [7:0] wda, wdb;

    flush_model();
    set_idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    // Traffic during reset and clear must be ignored.
    bus.rd_req_valid = 1'b1;
    bus.rd_addr_a    = 3'd1;
    bus.rd_addr_b    = 3'd1;
    bus.wb_valid_a   = 1'b1;
    bus.wb_addr_a    = 3'd1;
    bus.wb_data_a    = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
    chk("rst_rd_req_ready", 32'(bus.rd_req_ready), 32'd0);
    chk("rst_wb_ready", 32'(bus.wb_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rd_rsp_valid), 32'd0);
    chk("rst_rd_data_a", 32'(bus.rd_data_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    set_idle();

    // Cleared array, and the write offered during clear was dropped.
    cycle(1'b1, 3, 7, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00);
    cycle(1'b1, 1, 0, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00);
    // Write then read.
    cycle(1'b0, 0, 0, 1'b1, 2, 8'hA5, 1'b0, 0, 8'h00);
    cycle(1'b1, 2, 2, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00);
    // Same-cycle forwarding, then a later read of the stored values.
    cycle(1'b1, 4, 5, 1'b1, 4, 8'h11, 1'b1, 5, 8'h22);
    idle_cycle();
    cycle(1'b1, 4, 5, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00);
    // Write conflict with same-cycle read, then a later read.
    cycle(1'b1, 6, 4, 1'b1, 6, 8'h33, 1'b1, 6, 8'h44);
    cycle(1'b1, 6, 6, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00);
    // Zero register: write dropped, forwarding suppressed.
    cycle(1'b1, 0, 0, 1'b1, 0, 8'hFF, 1'b0, 0, 8'h00);
    cycle(1'b1, 0, 2, 1'b0, 0, 8'h00, 1'b1, 0, 8'hEE);
    idle_cycle();
    idle_cycle();

    // Back-to-back random traffic, biased towards address collisions.
    for (int i = 0; i < 40; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      ra  = $urandom_range(0, Depth - 1);
      rb  = $urandom_range(0, Depth - 1);
      wva = 1'($urandom_range(0, 1));
      wvb = 1'($urandom_range(0, 1));
      waa = $urandom_range(0, Depth - 1);
      wab = ($urandom_range(0, 2) == 0) ? waa : $urandom_range(0, Depth - 1);
      if ($urandom_range(0, 2) == 0) ra = waa;
      if ($urandom_range(0, 2) == 0) rb = wab;
      wda = 8'($urandom_range(0, 255));
      wdb = 8'($urandom_range(0, 255));
      cycle(rv, ra, rb, wva, waa, wda, wvb, wab, wdb);
    end
    idle_cycle();
    cycle(1'b0, 0, 0, 1'b1, 2, 8'hA5, 1'b0, 0, 8'h00);
    idle_cycle();
    idle_cycle();

    // Reset just after a request is accepted: the response must never appear.
    cycle(1'b1, 2, 6, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00);
    @(posedge clk);
    #1;
    set_idle();
    rst_n = 1'b0;
    flush_model();
    #1;
    chk("midrst_rsp_valid", 32'(bus.rd_rsp_valid), 32'd0);
    chk("midrst_rd_data_a", 32'(bus.rd_data_a), 32'd0);
    chk("midrst_init_done", 32'(bus.init_done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    // Data written before the reset must be cleared.
    cycle(1'b1, 2, 6, 1'b0, 0, 8'h00, 1'b0, 0, 8'h00);
    idle_cycle();
    idle_cycle();
    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
